// File: rtl/trunc_pkg.sv
// Shared widths and helper functions for the truncation arbiter.
package trunc_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned SEL_WIDTH  = $clog2(DATA_WIDTH);
  localparam int unsigned SEL_BITS   = SEL_WIDTH + 1;

  // Upper bound on requesters; the round-robin helper works on this fixed width.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_REQ_W = 3;

  localparam logic [SEL_BITS-1:0] SEL_MAX = SEL_BITS'(DATA_WIDTH);

  // Shifts beyond DATA_WIDTH would slice past the input word, so clamp them.
  function automatic logic [SEL_BITS-1:0] clamp_sel(input logic [SEL_BITS-1:0] sel);
    return (sel > SEL_MAX) ? SEL_MAX : sel;
  endfunction

  // One-hot grant for the first set bit of req at or above ptr, wrapping at num.
  function automatic logic [MAX_REQ-1:0] rr_onehot(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned       ptr,
                                                   input int unsigned       num);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= num) idx = idx - num;
      if ((k < num) && !found && req[idx[MAX_REQ_W-1:0]]) begin
        gnt[idx[MAX_REQ_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/trunc_arbiter_if.sv
// Request and output handshake bundle between the psum requesters and the arbiter.
interface trunc_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 1
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ*2*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]              req_ready;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [ID_WIDTH-1:0]             out_id;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

  // Requester / downstream side.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/trunc_arbiter_rr_grant.sv
// Combinational round-robin priority encoder: one-hot grant plus its index.
module rr_grant
  import trunc_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  input  logic                i_en,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic [MAX_REQ-1:0] w_full;

  assign w_full  = rr_onehot(MAX_REQ'(i_req), 32'(i_ptr), NUM_REQ);
  assign o_grant = w_full[NUM_REQ-1:0] & {NUM_REQ{i_en}};

  // Padding bits beyond NUM_REQ are always zero.
  if (NUM_REQ < MAX_REQ) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = |w_full[MAX_REQ-1:NUM_REQ];
  end

  // Encode the one-hot grant; zero when nothing is granted.
  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (o_grant[i]) o_idx = ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/truncator.sv
// Shift-and-truncate datapath: out = in[sel+DATA_WIDTH-1 : sel].
// With TRUNC_SAT_EN defined the input is signed and out-of-range results saturate.
module truncator
  import trunc_pkg::*;
(
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH:0]      i_sel,
  output logic [DATA_WIDTH-1:0]   o_data
`ifdef TRUNC_SAT_EN
  ,
  output logic                    o_sat
`endif
);

  logic [DATA_WIDTH-1:0] w_slice;

  assign w_slice = DATA_WIDTH'(i_data >> i_sel);

`ifdef TRUNC_SAT_EN
  // Bits from the kept sign position upward must all match for the slice to be exact.
  logic signed [2*DATA_WIDTH-1:0] w_hi;
  logic                           w_fits;

  assign w_hi   = $signed(i_data) >>> (int'(i_sel) + DATA_WIDTH - 1);
  assign w_fits = (w_hi == '0) || (w_hi == '1);
  assign o_sat  = !w_fits;
  assign o_data = w_fits ? w_slice :
                  (i_data[2*DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
  assign o_data = w_slice;
`endif

endmodule

// File: rtl/trunc_arbiter.sv
// Round-robin arbiter sharing one truncator among NUM_REQ psum requesters, with a
// one-entry valid/ready output register. DATA_WIDTH comes from trunc_pkg.
// Optional macro TRUNC_SAT_EN: signed saturation plus sticky o_sat_flag.
module trunc_arbiter
  import trunc_pkg::*;
#(
  parameter int unsigned  NUM_REQ  = 2,
  localparam int unsigned ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_we,
  input  logic [ID_WIDTH-1:0] i_cfg_idx,
  input  logic [SEL_WIDTH:0]  i_cfg_sel,
  trunc_arbiter_if.slave      bus
`ifdef TRUNC_SAT_EN
  ,
  output logic                o_sat_flag
`endif
);

  logic [SEL_WIDTH:0]      r_sel [NUM_REQ];
  logic [ID_WIDTH-1:0]     r_ptr;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [ID_WIDTH-1:0]     r_out_id;

  logic                    w_can_load;
  logic                    w_accept;
  logic [NUM_REQ-1:0]      w_grant;
  logic [ID_WIDTH-1:0]     w_gnt_idx;
  logic [2*DATA_WIDTH-1:0] w_gnt_data;
  logic [SEL_WIDTH:0]      w_gnt_sel;
  logic [DATA_WIDTH-1:0]   w_trunc;

  // Reset gating keeps req_ready low for the whole reset window.
  assign w_can_load = rst_n && (!r_out_valid || bus.out_ready);
  assign w_accept   = |w_grant;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_grant (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_can_load),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx)
  );

  assign w_gnt_data = bus.req_data[32'(w_gnt_idx)*2*DATA_WIDTH +: 2*DATA_WIDTH];
  assign w_gnt_sel  = r_sel[w_gnt_idx];

`ifdef TRUNC_SAT_EN
  logic w_sat;
  logic r_sat_flag;

  truncator u_truncator (
    .i_data (w_gnt_data),
    .i_sel  (w_gnt_sel),
    .o_data (w_trunc),
    .o_sat  (w_sat)
  );

  // Sticky saturation flag; a config write clears it, a saturating accept sets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_flag <= 1'b0;
    end else if (w_accept && w_sat) begin
      r_sat_flag <= 1'b1;
    end else if (i_cfg_we) begin
      r_sat_flag <= 1'b0;
    end
  end

  assign o_sat_flag = r_sat_flag;
`else
  truncator u_truncator (
    .i_data (w_gnt_data),
    .i_sel  (w_gnt_sel),
    .o_data (w_trunc)
  );
`endif

  // Per-requester shift registers; a same-cycle accept still sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_sel[i] <= '0;
    end else if (i_cfg_we && (32'(i_cfg_idx) < NUM_REQ)) begin
      r_sel[i_cfg_idx] <= clamp_sel(i_cfg_sel);
    end
  end

  // Round-robin pointer moves just past the requester that was accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      if (32'(w_gnt_idx) == NUM_REQ - 1) r_ptr <= '0;
      else                               r_ptr <= w_gnt_idx + 1'b1;
    end
  end

  // Output register: load on accept (even while draining), clear on a bare drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_trunc;
      r_out_id    <= w_gnt_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

endmodule
